// File: rtl/pipeline_fetch_unit.sv
// ============================================================================
// pipeline_fetch_unit : PC register, imem address mux, fetch and decode latches.
// Optional PIPE_FETCH_PERF_EN adds saturating stall/bubble counters. Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_fetch_unit #(
    parameter int                 PC_W      = 10,
    parameter int                 INSTR_W   = 18,
    parameter logic [PC_W-1:0]    RESET_VEC = 10'h000,
    parameter logic [PC_W-1:0]    INT_VEC   = 10'h3FF,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 18'h0_0000,
    parameter logic [INSTR_W-1:0] INT_INSTR = 18'h3_4000
`ifdef PIPE_FETCH_PERF_EN
    ,
    parameter int                 CNT_W     = 16
`endif
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pc_reset_i,
    input  logic               pc_load_i,
    input  logic               pc_inc_i,
    input  logic [2:0]         pc_mux_sel_i,
    input  logic [PC_W-1:0]    imm_target_i,
    input  logic [PC_W-1:0]    stack_target_i,
    input  logic [PC_W-1:0]    miss_target_i,
    input  logic [PC_W-1:0]    predict_target_i,
    input  logic               imem_addr_mux_i,
    input  logic               fetch_latch_stall_i,
    input  logic               dec_nop_i,
    input  logic               dec_int_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] dec_instr_o,
    output logic [PC_W-1:0]    dec_pc_o,
    output logic               dec_valid_o,
    output logic               dec_is_int_o
`ifdef PIPE_FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
`endif
);

    logic [PC_W-1:0]    pc_q, pc_d, load_target;
    logic [PC_W-1:0]    last_addr_q;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               fetch_valid_q, fetch_valid_d;
    logic [INSTR_W-1:0] dec_instr_q, dec_instr_d;
    logic [PC_W-1:0]    dec_pc_q, dec_pc_d;
    logic               dec_valid_q, dec_valid_d;
    logic               dec_is_int_q, dec_is_int_d;

    // Reserved selects (5..7) load the current PC, i.e. the PC holds.
    always_comb begin
        load_target = pc_q;
        case (pc_mux_sel_i)
            3'd0:    load_target = imm_target_i;
            3'd1:    load_target = stack_target_i;
            3'd2:    load_target = INT_VEC;
            3'd3:    load_target = miss_target_i;
            3'd4:    load_target = predict_target_i;
            default: load_target = pc_q;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (pc_reset_i)     pc_d = RESET_VEC;
        else if (pc_load_i) pc_d = load_target;
        else if (pc_inc_i)  pc_d = pc_q + PC_W'(1);
    end

    assign imem_addr_o = imem_addr_mux_i ? last_addr_q : pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        fetch_valid_d = fetch_valid_q;
        if (!fetch_latch_stall_i) begin
            fetch_pc_d    = imem_addr_o;
            fetch_valid_d = 1'b1;
        end
        if (pc_reset_i) fetch_valid_d = 1'b0;
    end

    always_comb begin
        dec_instr_d  = imem_data_i;
        dec_pc_d     = fetch_pc_q;
        dec_valid_d  = fetch_valid_q;
        dec_is_int_d = 1'b0;
        if (dec_int_i) begin
            // Return address for the interrupt is the word it displaces.
            dec_instr_d  = INT_INSTR;
            dec_valid_d  = 1'b1;
            dec_is_int_d = 1'b1;
        end else if (dec_nop_i) begin
            dec_instr_d  = NOP_INSTR;
            dec_pc_d     = dec_pc_q;
            dec_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q          <= RESET_VEC;
            last_addr_q   <= RESET_VEC;
            fetch_pc_q    <= '0;
            fetch_valid_q <= 1'b0;
            dec_instr_q   <= NOP_INSTR;
            dec_pc_q      <= '0;
            dec_valid_q   <= 1'b0;
            dec_is_int_q  <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            last_addr_q   <= imem_addr_o;
            fetch_pc_q    <= fetch_pc_d;
            fetch_valid_q <= fetch_valid_d;
            dec_instr_q   <= dec_instr_d;
            dec_pc_q      <= dec_pc_d;
            dec_valid_q   <= dec_valid_d;
            dec_is_int_q  <= dec_is_int_d;
        end
    end

    assign pc_o         = pc_q;
    assign dec_instr_o  = dec_instr_q;
    assign dec_pc_o     = dec_pc_q;
    assign dec_valid_o  = dec_valid_q;
    assign dec_is_int_o = dec_is_int_q;

`ifdef PIPE_FETCH_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, bubble_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (fetch_latch_stall_i && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (dec_nop_i && (bubble_cnt_q != '1))
                bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

`default_nettype wire
